// File: rtl/gcd_host_sequencer.sv
// gcd_host_sequencer: requester-side front end for the subtraction GCD engine.
// Takes operand pairs on a valid/ready request port, loads them into the
// engine over its shared load bus (A then B), waits for the sticky done and
// returns the result on a valid/ready response port. Zero operands bypass the
// engine (it would never finish), and a watchdog bounds the wait.
module gcd_host_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 70000,
  parameter int CWIDTH  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_gcd,
  output logic              rsp_err,
  output logic [CWIDTH-1:0] rsp_cycles,
  output logic              eng_start,
  output logic [WIDTH-1:0]  eng_dat,
  input  logic              eng_done,
  input  logic [WIDTH-1:0]  eng_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  ZERO_W     = {WIDTH{1'b0}};
  localparam logic [CWIDTH-1:0] ZERO_C     = {CWIDTH{1'b0}};
  localparam logic [CWIDTH-1:0] ONE_C      = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] TIMEOUT_C  = CWIDTH'(TIMEOUT);
  localparam logic [CWIDTH-1:0] LAST_C     = CWIDTH'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rsp_gcd_q, rsp_gcd_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CWIDTH-1:0] rsp_cycles_q, rsp_cycles_d;

  // Handshake flags and engine controls are pure decodes of the state register,
  // so reset drops them immediately and no input reaches an output directly.
  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign eng_start  = (state_q == S_LOAD_A);
  assign eng_dat    = (state_q == S_LOAD_A) ? a_q : b_q;
  assign rsp_gcd    = rsp_gcd_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

  // State register, operand capture, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= ZERO_W;
      b_q          <= ZERO_W;
      cnt_q        <= ZERO_C;
      rsp_gcd_q    <= ZERO_W;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= ZERO_C;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_gcd_q    <= rsp_gcd_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  // Next-state logic: request intake with zero bypass, engine load sequence,
  // watchdog-guarded wait for done, and response hold until accepted.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_gcd_d    = rsp_gcd_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          if ((req_a == ZERO_W) && (req_b == ZERO_W)) begin
            rsp_gcd_d    = ZERO_W;
            rsp_err_d    = 1'b1;
            rsp_cycles_d = ZERO_C;
            state_d      = S_RESP;
          end else if (req_a == ZERO_W) begin
            rsp_gcd_d    = req_b;
            rsp_err_d    = 1'b0;
            rsp_cycles_d = ZERO_C;
            state_d      = S_RESP;
          end else if (req_b == ZERO_W) begin
            rsp_gcd_d    = req_a;
            rsp_err_d    = 1'b0;
            rsp_cycles_d = ZERO_C;
            state_d      = S_RESP;
          end else begin
            state_d = S_LOAD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        cnt_d   = ZERO_C;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != TIMEOUT_C) begin
          cnt_d = cnt_q + ONE_C;
        end else begin
          cnt_d = cnt_q;
        end
        // Done takes priority over the watchdog when both land together.
        if (eng_done) begin
          rsp_gcd_d    = eng_result;
          rsp_err_d    = 1'b0;
          rsp_cycles_d = cnt_q;
          state_d      = S_RESP;
        end else if (cnt_q == LAST_C) begin
          rsp_gcd_d    = ZERO_W;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = TIMEOUT_C;
          state_d      = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Self-checking bench for gcd_host_sequencer: a behavioural subtraction engine
// model drives the engine side, and expected responses come from Euclid-based
// arithmetic (quotient sums give the engine's step count).
module tb_gcd_host_sequencer;
  localparam int W  = 16;
  localparam int TO = 16;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_gcd;
  logic          rsp_err;
  logic [CW-1:0] rsp_cycles;
  logic          eng_start;
  logic [W-1:0]  eng_dat;
  logic          eng_done;
  logic [W-1:0]  eng_result;

  int n_checks = 0;
  int n_pass   = 0;

  gcd_host_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd),
    .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
    .eng_start(eng_start), .eng_dat(eng_dat), .eng_done(eng_done),
    .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  // Engine model. Modes: 0 real subtraction, 1 hang, 2 oracle (done after
  // edelay steps with eres), 3 raise done immediately (stale-done source).
  int           emode  = 0;
  int           edelay = 0;
  logic [W-1:0] eres   = '0;
  logic [W-1:0] ea = '0, eb = '0;
  logic         ed = 1'b0, eb_load = 1'b0;
  int           esteps = 0;

  always @(posedge clk) begin
    if (eng_start) begin
      ea <= eng_dat; eb_load <= 1'b1; ed <= 1'b0; esteps <= 0;
    end else if (eb_load) begin
      eb <= eng_dat; eb_load <= 1'b0;
    end else if (!ed) begin
      case (emode)
        0: begin
          if (ea == eb) ed <= 1'b1;
          else if (ea > eb) ea <= ea - eb;
          else eb <= eb - ea;
        end
        2: begin
          esteps <= esteps + 1;
          if (esteps + 1 == edelay) begin ed <= 1'b1; ea <= eres; end
        end
        3: ed <= 1'b1;
        default: ;
      endcase
    end
  end
  assign eng_done   = ed;
  assign eng_result = ea;

  // Monitor of the engine load bus: counts start pulses and records A/B.
  int           start_cnt = 0;
  logic         prev_start = 1'b0;
  logic [W-1:0] a_seen = '0, b_seen = '0;
  always @(negedge clk) begin
    if (eng_start) begin start_cnt <= start_cnt + 1; a_seen <= eng_dat; end
    if (prev_start) b_seen <= eng_dat;
    prev_start <= eng_start;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int gcd_of(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Steps a subtraction engine takes, including its final equality check,
  // equals the sum of Euclid quotients.
  function automatic int quot_sum(input int a, input int b);
    int s = 0;
    int t;
    while (b != 0) begin s += a / b; t = a % b; a = b; b = t; end
    return s;
  endfunction

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_req_ready"},  int'(req_ready), 1);
    check_eq({pfx, "_rsp_valid"},  int'(rsp_valid), 0);
    check_eq({pfx, "_eng_start"},  int'(eng_start), 0);
    check_eq({pfx, "_eng_dat"},    int'(eng_dat), 0);
    check_eq({pfx, "_rsp_gcd"},    int'(rsp_gcd), 0);
    check_eq({pfx, "_rsp_err"},    int'(rsp_err), 0);
    check_eq({pfx, "_rsp_cycles"}, int'(rsp_cycles), 0);
  endtask

  task automatic run_req(input int a, input int b, input int mode,
                         input int delay, input int hold);
    int k, g, lat, s0, w, exp_gcd, exp_err, exp_cyc, exp_lat;
    bit bypass;
    emode = mode; edelay = delay; eres = W'(gcd_of(a, b));
    if (a == 0 && b == 0) begin
      bypass = 1'b1; exp_gcd = 0; exp_err = 1; exp_cyc = 0;
    end else if (a == 0 || b == 0) begin
      bypass = 1'b1; exp_gcd = a + b; exp_err = 0; exp_cyc = 0;
    end else begin
      bypass = 1'b0;
      g = gcd_of(a, b);
      if (mode == 0) k = quot_sum(a, b);
      else if (mode == 2) k = delay;
      else k = 1000000;
      if (k <= TO - 1) begin exp_gcd = g; exp_err = 0; exp_cyc = k; end
      else begin exp_gcd = 0; exp_err = 1; exp_cyc = TO; end
    end
    // Edges from handshake to rsp_valid: bypass 1; else LOAD_A, LOAD_B, then
    // WAIT until the counter reaches exp_cyc, plus one edge on done.
    exp_lat = bypass ? 1 : (3 + exp_cyc + (exp_err != 0 ? 0 : 1));

    req_a = W'(a); req_b = W'(b); req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    check_eq("req_ready_wait", int'(req_ready), 1);
    s0 = start_cnt;
    @(posedge clk); #1;
    // Keep req_valid high with junk: must be ignored while busy.
    req_a = W'($urandom); req_b = W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_gcd", int'(rsp_gcd), exp_gcd);
    check_eq("rsp_err", int'(rsp_err), exp_err);
    check_eq("rsp_cycles", int'(rsp_cycles), exp_cyc);
    check_eq("start_count", start_cnt - s0, bypass ? 0 : 1);
    if (!bypass) begin
      check_eq("eng_dat_a", int'(a_seen), a);
      check_eq("eng_dat_b", int'(b_seen), b);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", int'(rsp_valid), 1);
      check_eq("hold_req_ready", int'(req_ready), 0);
      check_eq("hold_gcd", int'(rsp_gcd), exp_gcd);
      check_eq("hold_err", int'(rsp_err), exp_err);
      check_eq("hold_cycles", int'(rsp_cycles), exp_cyc);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_dropped", int'(rsp_valid), 0);
    check_eq("idle_ready", int'(req_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(48, 18, 0, 0, 0);
    run_req(0, 7, 0, 0, 0);
    run_req(0, 0, 0, 0, 0);
    run_req(9, 6, 1, 0, 0);            // engine hangs: watchdog
    run_req(9, 6, 2, TO - 1, 0);       // done at the last counter value
    eres = 16'd5;
    run_req(40, 15, 0, 0, 5);          // response held for 5 cycles
    run_req(65535, 1, 2, 3, 0);

    // Reset while waiting, with done already raised by the engine.
    emode = 1;
    req_a = 16'd9; req_b = 16'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    emode = 3;
    @(posedge clk); #1;
    check_eq("stale_done_high", int'(eng_done), 1);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    emode = 0;
    check_eq("stale_done_kept", int'(eng_done), 1);
    run_req(12, 8, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      run_req(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 0, 0,
              int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
